control_sequencer: RTL and testbench
====================================

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 clock  input  1  sole clock; all state changes on rising edge.
REQ-002 reset  input  1  synchronous, active-high; sampled on rising edge of clock.
REQ-003 IR  input  32  current instruction; opcode IR[31:27], Ra IR[26:23], Rb IR[22:19], Rc IR[18:15], C IR[18:0].
REQ-004 CON_FF  input  1  registered branch-condition result; valid from the state after CONin.
REQ-005 mem_ready  input  1  memory completion strobe; used only when MEM_WAIT_EN is defined.
REQ-006 Gra, Grb, Grc  output  1 each  register-field selects into the register select/encode logic.
REQ-007 Rin, Rout, BAout  output  1 each  register-file write, read and base-address-read strobes.
REQ-008 PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin, Yin, Zin, Zlowout, Cout, CONin  output  1 each  datapath bus and load strobes.
REQ-009 Read, Write  output  1 each  memory read and write requests.
REQ-010 ALU_op  output  5  ALU operation code; ADD = 5'b00011 whenever an address or PC sum is formed.
REQ-011 Run  output  1  1 while executing, 0 once halted.
REQ-012 illegal  output  1  one-cycle pulse on an undefined opcode.

Function
REQ-013 The FSM SHALL be Moore; outputs decode from state and IR only, except PCin in BR_T6, which is gated by CON_FF.
REQ-014 States SHALL be RST, T0-T7 and HALT; every state not listed below drives all strobes 0.
REQ-015 Fetch SHALL proceed: T0 {PCout, MARin, IncPC, Zin} -> T1 {Zlowout, PCin, Read, MDRin} -> T2 {MDRout, IRin} -> T3.
REQ-016 Opcodes SHALL be decoded at T3: ld 00000, ldi 00001, st 00010, add 00011, sub 00100, and 00101, or 00110, addi 01011, br 10010, nop 11010, halt 11011.
REQ-017 add/sub/and/or SHALL run: T3 {Grb, Rout, Yin} -> T4 {Grc, Rout, Zin, ALU_op = opcode} -> T5 {Zlowout, Gra, Rin} -> T0.
REQ-018 addi/ldi SHALL run: T3 {Grb, BAout, Yin} -> T4 {Cout, Zin, ALU_op = ADD} -> T5 {Zlowout, Gra, Rin} -> T0.
REQ-019 ld SHALL run: T3-T4 as addi -> T5 {Zlowout, MARin} -> T6 {Read, MDRin} -> T7 {MDRout, Gra, Rin} -> T0.
REQ-020 st SHALL run: T3-T4 as addi -> T5 {Zlowout, MARin} -> T6 {Gra, Rout, MDRin} -> T7 {Write} -> T0.
REQ-021 br SHALL run: T3 {Gra, Rout, CONin} -> T4 {PCout, Yin} -> T5 {Cout, Zin, ALU_op = ADD} -> T6 {Zlowout, PCin = CON_FF} -> T0.
REQ-022 nop SHALL go T3 -> T0 with no strobes; halt SHALL go T3 -> HALT.
REQ-023 An undefined opcode SHALL pulse illegal for one cycle in T3 and proceed to T0 as nop.
REQ-024 HALT SHALL hold Run = 0, drive all strobes 0 and persist until reset.
REQ-025 At most one of Gra/Grb/Grc and at most one of Rin/Rout/BAout SHALL be asserted in any state.

Reset
REQ-026 reset = 1 SHALL force state RST at the next edge, from any state, including mid-instruction and HALT.
REQ-027 In RST all strobes and illegal SHALL be 0, ALU_op SHALL be 0 and Run SHALL be 1; the next state SHALL be T0 when reset = 0.
REQ-028 reset SHALL take priority over all other inputs, including mem_ready.

Configuration
REQ-029 Macro CONTROL_SEQUENCER_MEM_WAIT_EN SHALL select memory wait behaviour.
REQ-030 When defined: T1, ld T6 and st T7 SHALL hold their outputs and state until mem_ready = 1, then advance on that edge; mem_ready = 1 on entry SHALL advance after one cycle.
REQ-031 When undefined: mem_ready SHALL be ignored and every memory state SHALL last exactly one cycle.

Verification
REQ-032 Reset, then IR = 0x19890000 (add r3,r1,r2): T0..T5 in 6 cycles; T4 shows Grc, Rout, ALU_op = 00011; T5 shows Gra, Rin; then T0.
REQ-033 IR = 0x00900045 (ld r1,0x45(r2)): 8-cycle instruction; T3 shows Grb, BAout; T6 shows Read; T7 shows MDRout, Gra, Rin.
REQ-034 br with CON_FF = 0, then with CON_FF = 1: PCin stays 0 in T6 for the first and is 1 in T6 for the second.
REQ-035 IR = 0xD8000000 (halt): Run falls to 0 after T3 and stays 0 for 20 cycles; reset then gives RST, then T0 with Run = 1.
REQ-036 With MEM_WAIT_EN defined and mem_ready held 0 for 3 cycles in T1, state stays T1 with Read = 1 for 4 cycles; undefined opcode 11111 pulses illegal once.
REQ-037 reset asserted in st T6: Write is never asserted; RST follows, then T0.

Source files
------------

// File: rtl/control_sequencer.sv
// control_sequencer: Moore control FSM sequencing fetch/execute strobes for a single-bus CPU datapath.
// Latency: 3-cycle fetch (T0-T2), then 1 to 5 execute cycles; outputs decode from state and IR only.
// Backpressure: with CONTROL_SEQUENCER_MEM_WAIT_EN defined, T1, ld T6 and st T7 stall until mem_ready.
module control_sequencer (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] IR,
  input  logic        CON_FF,
  input  logic        mem_ready,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        BAout,
  output logic        PCout,
  output logic        PCin,
  output logic        IncPC,
  output logic        MARin,
  output logic        MDRin,
  output logic        MDRout,
  output logic        IRin,
  output logic        Yin,
  output logic        Zin,
  output logic        Zlowout,
  output logic        Cout,
  output logic        CONin,
  output logic        Read,
  output logic        Write,
  output logic [4:0]  ALU_op,
  output logic        Run,
  output logic        illegal
);

  typedef enum logic [3:0] {
    S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_t;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ADDI = 5'b01011;
  localparam logic [4:0] OP_BR   = 5'b10010;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  state_t     state, next_state;
  logic [4:0] opcode;
  logic       is_alu, is_imm, is_mem;
  logic       mem_go;
  logic       unused_ir;

  assign opcode = IR[31:27];
  assign is_alu = (opcode == OP_ADD) || (opcode == OP_SUB) ||
                  (opcode == OP_AND) || (opcode == OP_OR);
  assign is_imm = (opcode == OP_ADDI) || (opcode == OP_LDI);
  assign is_mem = (opcode == OP_LD) || (opcode == OP_ST);

  // Register fields are decoded downstream; only the opcode matters here.
`ifdef CONTROL_SEQUENCER_MEM_WAIT_EN
  assign mem_go    = mem_ready;
  assign unused_ir = ^IR[26:0];
`else
  assign mem_go    = 1'b1;
  assign unused_ir = ^{IR[26:0], mem_ready};
`endif

  // State register; reset wins over everything, including a pending mem_ready.
  always_ff @(posedge clock) begin
    if (reset) state <= S_RST;
    else       state <= next_state;
  end

  // Next-state and Moore output decode; PCin in br T6 is the only input-gated output.
  always_comb begin
    next_state = state;
    Gra = 1'b0; Grb = 1'b0; Grc = 1'b0;
    Rin = 1'b0; Rout = 1'b0; BAout = 1'b0;
    PCout = 1'b0; PCin = 1'b0; IncPC = 1'b0; MARin = 1'b0;
    MDRin = 1'b0; MDRout = 1'b0; IRin = 1'b0; Yin = 1'b0;
    Zin = 1'b0; Zlowout = 1'b0; Cout = 1'b0; CONin = 1'b0;
    Read = 1'b0; Write = 1'b0;
    ALU_op = 5'b00000;
    Run = 1'b1;
    illegal = 1'b0;
    case (state)
      S_RST: next_state = S_T0;
      S_T0: begin
        PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1;
        next_state = S_T1;
      end
      S_T1: begin
        Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1;
        if (mem_go) next_state = S_T2;
      end
      S_T2: begin
        MDRout = 1'b1; IRin = 1'b1;
        next_state = S_T3;
      end
      S_T3: begin
        if (is_alu) begin
          Grb = 1'b1; Rout = 1'b1; Yin = 1'b1;
          next_state = S_T4;
        end else if (is_imm || is_mem) begin
          Grb = 1'b1; BAout = 1'b1; Yin = 1'b1;
          next_state = S_T4;
        end else if (opcode == OP_BR) begin
          Gra = 1'b1; Rout = 1'b1; CONin = 1'b1;
          next_state = S_T4;
        end else if (opcode == OP_HALT) begin
          next_state = S_HALT;
        end else if (opcode == OP_NOP) begin
          next_state = S_T0;
        end else begin
          illegal = 1'b1;
          next_state = S_T0;
        end
      end
      S_T4: begin
        next_state = S_T5;
        if (is_alu) begin
          Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; ALU_op = opcode;
        end else if (is_imm || is_mem) begin
          Cout = 1'b1; Zin = 1'b1; ALU_op = OP_ADD;
        end else if (opcode == OP_BR) begin
          PCout = 1'b1; Yin = 1'b1;
        end else begin
          next_state = S_T0;
        end
      end
      S_T5: begin
        next_state = S_T0;
        if (is_alu || is_imm) begin
          Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
        end else if (is_mem) begin
          Zlowout = 1'b1; MARin = 1'b1;
          next_state = S_T6;
        end else if (opcode == OP_BR) begin
          Cout = 1'b1; Zin = 1'b1; ALU_op = OP_ADD;
          next_state = S_T6;
        end
      end
      S_T6: begin
        next_state = S_T0;
        if (opcode == OP_LD) begin
          Read = 1'b1; MDRin = 1'b1;
          next_state = mem_go ? S_T7 : S_T6;
        end else if (opcode == OP_ST) begin
          Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1;
          next_state = S_T7;
        end else if (opcode == OP_BR) begin
          Zlowout = 1'b1; PCin = CON_FF;
        end
      end
      S_T7: begin
        next_state = S_T0;
        if (opcode == OP_LD) begin
          MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1;
        end else if (opcode == OP_ST) begin
          Write = 1'b1;
          if (!mem_go) next_state = S_T7;
        end
      end
      S_HALT: Run = 1'b0;
      default: next_state = S_RST;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: directed vector table plus hand-written multi-cycle sequences for control_sequencer.
// Inputs change on the falling edge; outputs are compared 1 time unit later.
// Memory-wait sequences adapt to whether CONTROL_SEQUENCER_MEM_WAIT_EN is defined.
module tb_control_sequencer;

  logic        clock = 1'b0;
  logic        reset, CON_FF, mem_ready;
  logic [31:0] IR;
  logic Gra, Grb, Grc, Rin, Rout, BAout, PCout, PCin, IncPC, MARin, MDRin, MDRout;
  logic IRin, Yin, Zin, Zlowout, Cout, CONin, Read, Write, Run, illegal;
  logic [4:0]  ALU_op;
  logic [19:0] stb_obs;

  localparam logic [19:0] GRA = 20'h80000, GRB = 20'h40000, GRC = 20'h20000, RIN = 20'h10000;
  localparam logic [19:0] ROUT = 20'h08000, BAOUT = 20'h04000, PCOUT = 20'h02000, PCIN = 20'h01000;
  localparam logic [19:0] INCPC = 20'h00800, MARIN = 20'h00400, MDRIN = 20'h00200, MDROUT = 20'h00100;
  localparam logic [19:0] IRIN = 20'h00080, YIN = 20'h00040, ZIN = 20'h00020, ZLOW = 20'h00010;
  localparam logic [19:0] COUT = 20'h00008, CONIN = 20'h00004, READ = 20'h00002, WRITE = 20'h00001;
  localparam logic [19:0] NONE = 20'h00000;
  localparam logic [19:0] T0_S = PCOUT | MARIN | INCPC | ZIN;
  localparam logic [19:0] T1_S = ZLOW | PCIN | READ | MDRIN;
  localparam logic [19:0] T2_S = MDROUT | IRIN;

  localparam logic [31:0] I_ADD  = 32'h19890000;
  localparam logic [31:0] I_LD   = 32'h00900045;
  localparam logic [31:0] I_LDI  = 32'h08000000;
  localparam logic [31:0] I_ST   = 32'h10000000;
  localparam logic [31:0] I_SUB  = 32'h20000000;
  localparam logic [31:0] I_AND  = 32'h28000000;
  localparam logic [31:0] I_OR   = 32'h30000000;
  localparam logic [31:0] I_ADDI = 32'h58000000;
  localparam logic [31:0] I_BR   = 32'h90000000;
  localparam logic [31:0] I_NOP  = 32'hD0000000;
  localparam logic [31:0] I_HALT = 32'hD8000000;
  localparam logic [31:0] I_BAD  = 32'hF8000000;

  typedef struct {
    logic        rst;
    logic [31:0] ir;
    logic        con;
    logic [19:0] stb;
    logic [4:0]  alu;
    logic        ill;
  } vec_t;

  vec_t vecs[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  control_sequencer dut (
    .clock(clock), .reset(reset), .IR(IR), .CON_FF(CON_FF), .mem_ready(mem_ready),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
    .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin), .MDRin(MDRin),
    .MDRout(MDRout), .IRin(IRin), .Yin(Yin), .Zin(Zin), .Zlowout(Zlowout),
    .Cout(Cout), .CONin(CONin), .Read(Read), .Write(Write), .ALU_op(ALU_op),
    .Run(Run), .illegal(illegal)
  );

  assign stb_obs = {Gra, Grb, Grc, Rin, Rout, BAout, PCout, PCin, IncPC, MARin, MDRin,
                    MDRout, IRin, Yin, Zin, Zlowout, Cout, CONin, Read, Write};

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [19:0] es, input logic [4:0] ea,
                       input logic er, input logic ei);
    n_vec++;
    if (stb_obs !== es || ALU_op !== ea || Run !== er || illegal !== ei) begin
      n_miss++;
      $display("FAIL %s: got stb=%h alu=%b run=%b ill=%b, want stb=%h alu=%b run=%b ill=%b",
               name, stb_obs, ALU_op, Run, illegal, es, ea, er, ei);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic av(input logic rst, input logic [31:0] ir, input logic con,
                    input logic [19:0] stb, input logic [4:0] alu, input logic ill);
    vec_t v;
    v.rst = rst; v.ir = ir; v.con = con; v.stb = stb; v.alu = alu; v.ill = ill;
    vecs.push_back(v);
  endtask

  task automatic fetch(input logic [31:0] ir, input logic con);
    av(1'b0, ir, con, T0_S, 5'd0, 1'b0);
    av(1'b0, ir, con, T1_S, 5'd0, 1'b0);
    av(1'b0, ir, con, T2_S, 5'd0, 1'b0);
  endtask

  task automatic alu_instr(input logic [31:0] ir, input logic [4:0] op);
    fetch(ir, 1'b0);
    av(1'b0, ir, 1'b0, GRB | ROUT | YIN, 5'd0, 1'b0);
    av(1'b0, ir, 1'b0, GRC | ROUT | ZIN, op, 1'b0);
    av(1'b0, ir, 1'b0, ZLOW | GRA | RIN, 5'd0, 1'b0);
  endtask

  task automatic imm_instr(input logic [31:0] ir);
    fetch(ir, 1'b0);
    av(1'b0, ir, 1'b0, GRB | BAOUT | YIN, 5'd0, 1'b0);
    av(1'b0, ir, 1'b0, COUT | ZIN, 5'b00011, 1'b0);
  endtask

  task automatic br_instr(input logic con);
    fetch(I_BR, con);
    av(1'b0, I_BR, con, GRA | ROUT | CONIN, 5'd0, 1'b0);
    av(1'b0, I_BR, con, PCOUT | YIN, 5'd0, 1'b0);
    av(1'b0, I_BR, con, COUT | ZIN, 5'b00011, 1'b0);
    av(1'b0, I_BR, con, con ? (ZLOW | PCIN) : ZLOW, 5'd0, 1'b0);
  endtask

  initial begin
    // Vector table: each entry is the inputs for one cycle and the outputs expected in it.
    av(1'b1, I_ADD, 1'b0, NONE, 5'd0, 1'b0);
    av(1'b0, I_ADD, 1'b0, NONE, 5'd0, 1'b0);
    alu_instr(I_ADD, 5'b00011);
    imm_instr(I_LD);
    av(1'b0, I_LD, 1'b0, ZLOW | MARIN, 5'd0, 1'b0);
    av(1'b0, I_LD, 1'b0, READ | MDRIN, 5'd0, 1'b0);
    av(1'b0, I_LD, 1'b0, MDROUT | GRA | RIN, 5'd0, 1'b0);
    br_instr(1'b0);
    br_instr(1'b1);
    alu_instr(I_SUB, 5'b00100);
    alu_instr(I_AND, 5'b00101);
    alu_instr(I_OR, 5'b00110);
    imm_instr(I_ADDI);
    av(1'b0, I_ADDI, 1'b0, ZLOW | GRA | RIN, 5'd0, 1'b0);
    imm_instr(I_LDI);
    av(1'b0, I_LDI, 1'b0, ZLOW | GRA | RIN, 5'd0, 1'b0);
    imm_instr(I_ST);
    av(1'b0, I_ST, 1'b0, ZLOW | MARIN, 5'd0, 1'b0);
    av(1'b0, I_ST, 1'b0, GRA | ROUT | MDRIN, 5'd0, 1'b0);
    av(1'b0, I_ST, 1'b0, WRITE, 5'd0, 1'b0);
    fetch(I_NOP, 1'b0);
    av(1'b0, I_NOP, 1'b0, NONE, 5'd0, 1'b0);
    fetch(I_BAD, 1'b0);
    av(1'b0, I_BAD, 1'b0, NONE, 5'd0, 1'b1);
    av(1'b0, I_BAD, 1'b0, T0_S, 5'd0, 1'b0);

    reset = 1'b1; IR = I_ADD; CON_FF = 1'b0; mem_ready = 1'b1;
    cyc();
    foreach (vecs[i]) begin
      reset = vecs[i].rst; IR = vecs[i].ir; CON_FF = vecs[i].con; mem_ready = 1'b1;
      #1;
      check($sformatf("vec%0d", i), vecs[i].stb, vecs[i].alu, 1'b1, vecs[i].ill);
      cyc();
    end

    // halt: Run drops after T3 and holds until reset.
    reset = 1'b1; IR = I_HALT; CON_FF = 1'b0;
    cyc();
    reset = 1'b0;
    cyc(); cyc(); cyc(); cyc();
    #1 check("halt_t3", NONE, 5'd0, 1'b1, 1'b0);
    cyc();
    for (int k = 0; k < 20; k++) begin
      #1 check($sformatf("halt_hold%0d", k), NONE, 5'd0, 1'b0, 1'b0);
      cyc();
    end
    reset = 1'b1;
    cyc();
    #1 check("halt_rst", NONE, 5'd0, 1'b1, 1'b0);
    reset = 1'b0;
    cyc();
    #1 check("halt_t0", T0_S, 5'd0, 1'b1, 1'b0);

    // st interrupted by reset in T6: Write must never appear.
    IR = I_ST;
    cyc(); cyc(); cyc(); cyc(); cyc(); cyc();
    #1 check("st_t6", GRA | ROUT | MDRIN, 5'd0, 1'b1, 1'b0);
    reset = 1'b1;
    cyc();
    #1 check("st_rst", NONE, 5'd0, 1'b1, 1'b0);
    reset = 1'b0;
    cyc();
    #1 check("st_t0", T0_S, 5'd0, 1'b1, 1'b0);

    // Memory-state timing with mem_ready low.
    IR = I_LD; mem_ready = 1'b0;
    cyc();
`ifdef CONTROL_SEQUENCER_MEM_WAIT_EN
    for (int k = 0; k < 4; k++) begin
      mem_ready = (k == 3);
      #1 check($sformatf("t1_wait%0d", k), T1_S, 5'd0, 1'b1, 1'b0);
      cyc();
    end
`else
    #1 check("t1_nowait", T1_S, 5'd0, 1'b1, 1'b0);
    cyc();
`endif
    mem_ready = 1'b0;
    #1 check("ld_t2", T2_S, 5'd0, 1'b1, 1'b0);
    cyc(); cyc(); cyc(); cyc();
`ifdef CONTROL_SEQUENCER_MEM_WAIT_EN
    for (int k = 0; k < 3; k++) begin
      mem_ready = (k == 2);
      #1 check($sformatf("t6_wait%0d", k), READ | MDRIN, 5'd0, 1'b1, 1'b0);
      cyc();
    end
`else
    #1 check("t6_nowait", READ | MDRIN, 5'd0, 1'b1, 1'b0);
    cyc();
`endif
    #1 check("ld_t7", MDROUT | GRA | RIN, 5'd0, 1'b1, 1'b0);
    cyc(); cyc();

    // Reset beats mem_ready in T1.
    reset = 1'b1; mem_ready = 1'b1;
    #1 check("prio_t1", T1_S, 5'd0, 1'b1, 1'b0);
    cyc();
    #1 check("prio_rst", NONE, 5'd0, 1'b1, 1'b0);
    reset = 1'b0;
    cyc();
    #1 check("prio_t0", T0_S, 5'd0, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
